// File: rtl/clk_rst_sequencer.sv
// PLL reset pulse, LOCK synchronizer and core-reset release sequencer for the iCE40 PLL.
// Optional lock-acquisition timeout is compiled in with `define CLK_RST_TIMEOUT_EN.
module clk_rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lock_in,
    input  logic             soft_rst_req,
    output logic             pll_resetb,
    output logic             core_reset,
    output logic             clk_ok,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic             timeout
);

    localparam int SEQ_MAX = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam logic [SEQ_W-1:0] PLL_LAST    = SEQ_W'(PLL_RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0] STABLE_LAST = SEQ_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || PLL_RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("clk_rst_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT_RST  = 3'd4
    } state_e;

    state_e                 state_r;
    state_e                 state_next_s;
    logic [SEQ_W-1:0]       cnt_r;
    logic [SEQ_W-1:0]       cnt_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_sync_s;
    logic                   loss_event_s;
    logic                   timer_expired_s;
    logic                   pll_resetb_s;
    logic                   core_reset_s;
    logic                   clk_ok_s;
    logic [CNT_W-1:0]       loss_count_next_s;

    // LOCK synchronizer: the FSM only ever looks at the last stage
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], lock_in};
        end
    end

    assign lock_sync_s = sync_r[SYNC_STAGES-1];

`ifdef CLK_RST_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer_r;
    logic             timeout_r;

    // Acquisition timer: counts while hunting for lock, restarts with every PLL reset
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r   <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r | timer_expired_s;
            if (state_next_s == ST_PLL_RST) begin
                timer_r <= '0;
            end else if (state_r == ST_WAIT_LOCK || state_r == ST_STABILIZE) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    assign timer_expired_s = (state_r == ST_WAIT_LOCK || state_r == ST_STABILIZE) && (timer_r == TMR_LAST);
    assign timeout         = timeout_r;
`else
    assign timer_expired_s = 1'b0;
    assign timeout         = 1'b0;
`endif

    // State and sequence counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_PLL_RST;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; a lock loss always wins over a soft reset request
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        loss_event_s = 1'b0;
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == PLL_LAST) begin
                    state_next_s = ST_WAIT_LOCK;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + SEQ_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (timer_expired_s) begin
                    state_next_s = ST_PLL_RST;
                    cnt_next_s   = '0;
                end else if (lock_sync_s) begin
                    state_next_s = ST_STABILIZE;
                    cnt_next_s   = SEQ_W'(1);
                end else begin
                    cnt_next_s   = '0;
                end
            end
            ST_STABILIZE: begin
                if (timer_expired_s) begin
                    state_next_s = ST_PLL_RST;
                    cnt_next_s   = '0;
                end else if (!lock_sync_s) begin
                    state_next_s = ST_WAIT_LOCK;
                    cnt_next_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + SEQ_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_sync_s) begin
                    state_next_s = ST_PLL_RST;
                    cnt_next_s   = '0;
                    loss_event_s = 1'b1;
                end else if (soft_rst_req) begin
                    state_next_s = ST_SOFT_RST;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = '0;
                end
            end
            ST_SOFT_RST: begin
                if (!lock_sync_s) begin
                    state_next_s = ST_PLL_RST;
                    cnt_next_s   = '0;
                    loss_event_s = 1'b1;
                end else if (cnt_r == PLL_LAST) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + SEQ_W'(1);
                end
            end
            default: begin
                state_next_s = ST_PLL_RST;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Output decode from the state being entered, so registered outputs change on the transition edge
    always_comb begin
        pll_resetb_s = 1'b1;
        core_reset_s = 1'b1;
        clk_ok_s     = 1'b0;
        case (state_next_s)
            ST_PLL_RST:   pll_resetb_s = 1'b0;
            ST_WAIT_LOCK: pll_resetb_s = 1'b1;
            ST_STABILIZE: pll_resetb_s = 1'b1;
            ST_RUN: begin
                core_reset_s = 1'b0;
                clk_ok_s     = 1'b1;
            end
            ST_SOFT_RST:  pll_resetb_s = 1'b1;
            default:      pll_resetb_s = 1'b0;
        endcase
        if (loss_event_s && (lock_loss_count != LOSS_MAX)) begin
            loss_count_next_s = lock_loss_count + CNT_W'(1);
        end else begin
            loss_count_next_s = lock_loss_count;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pll_resetb      <= 1'b0;
            core_reset      <= 1'b1;
            clk_ok          <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            pll_resetb      <= pll_resetb_s;
            core_reset      <= core_reset_s;
            clk_ok          <= clk_ok_s;
            lock_loss_count <= loss_count_next_s;
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed self-checking bench for clk_rst_sequencer (PLL_RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32).
// Timeout expectations follow `define CLK_RST_TIMEOUT_EN when the bench is built with it.
module tb_clk_rst_sequencer;

    logic       clk;
    logic       reset;
    logic       lock_in;
    logic       soft_rst_req;
    logic       pll_resetb;
    logic       core_reset;
    logic       clk_ok;
    logic [7:0] lock_loss_count;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    clk_rst_sequencer #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .STABLE_CYCLES (8),
        .CNT_W         (8),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lock_in        (lock_in),
        .soft_rst_req   (soft_rst_req),
        .pll_resetb     (pll_resetb),
        .core_reset     (core_reset),
        .clk_ok         (clk_ok),
        .lock_loss_count(lock_loss_count),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lock_val);
        reset        = 1'b1;
        soft_rst_req = 1'b0;
        lock_in      = lock_val;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        lock_in      = 1'b1;
        soft_rst_req = 1'b1;
        repeat (3) step();
        soft_rst_req = 1'b0;
        n_checks++; if (pll_resetb !== 1'b0) $display("FAIL reset_pll_resetb got %b want 0", pll_resetb); else n_pass++;
        n_checks++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset got %b want 1", core_reset); else n_pass++;
        n_checks++; if (clk_ok !== 1'b0) $display("FAIL reset_clk_ok got %b want 0", clk_ok); else n_pass++;
        n_checks++; if (lock_loss_count !== 8'd0) $display("FAIL reset_count got %0d want 0", lock_loss_count); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else n_pass++;
    endtask

    task automatic test_power_up();
        do_reset(1'b1);
        for (int n = 1; n <= 14; n++) begin
            step();
            n_checks++; if (pll_resetb !== (n >= 4)) $display("FAIL pwr_pll_resetb edge %0d got %b want %b", n, pll_resetb, (n >= 4)); else n_pass++;
            n_checks++; if (core_reset !== (n < 12)) $display("FAIL pwr_core_reset edge %0d got %b want %b", n, core_reset, (n < 12)); else n_pass++;
            n_checks++; if (clk_ok !== (n >= 12)) $display("FAIL pwr_clk_ok edge %0d got %b want %b", n, clk_ok, (n >= 12)); else n_pass++;
        end
        n_checks++; if (lock_loss_count !== 8'd0) $display("FAIL pwr_count got %0d want 0", lock_loss_count); else n_pass++;
    endtask

    // lock_sync re-rises after edge 11, so release is 8 edges later at edge 19
    task automatic test_glitch();
        do_reset(1'b0);
        for (int n = 1; n <= 21; n++) begin
            if (n == 5)  lock_in = 1'b1;
            if (n == 9)  lock_in = 1'b0;
            if (n == 10) lock_in = 1'b1;
            step();
            n_checks++; if (pll_resetb !== (n >= 4)) $display("FAIL glitch_pll_resetb edge %0d got %b want %b", n, pll_resetb, (n >= 4)); else n_pass++;
            n_checks++; if (core_reset !== (n < 19)) $display("FAIL glitch_core_reset edge %0d got %b want %b", n, core_reset, (n < 19)); else n_pass++;
            n_checks++; if (clk_ok !== (n >= 19)) $display("FAIL glitch_clk_ok edge %0d got %b want %b", n, clk_ok, (n >= 19)); else n_pass++;
        end
        n_checks++; if (lock_loss_count !== 8'd0) $display("FAIL glitch_count got %0d want 0", lock_loss_count); else n_pass++;
    endtask

    // Starts in RUN; lock_sync is low from edge 2, FSM leaves RUN on edge 3
    task automatic test_lock_loss();
        logic exp_pll;
        logic exp_core;
        for (int j = 1; j <= 17; j++) begin
            if (j == 1) lock_in = 1'b0;
            if (j == 4) lock_in = 1'b1;
            step();
            exp_pll  = !(j >= 3 && j <= 6);
            exp_core = (j >= 3 && j < 15);
            n_checks++; if (pll_resetb !== exp_pll) $display("FAIL loss_pll_resetb j=%0d got %b want %b", j, pll_resetb, exp_pll); else n_pass++;
            n_checks++; if (core_reset !== exp_core) $display("FAIL loss_core_reset j=%0d got %b want %b", j, core_reset, exp_core); else n_pass++;
            n_checks++; if (clk_ok !== !exp_core) $display("FAIL loss_clk_ok j=%0d got %b want %b", j, clk_ok, !exp_core); else n_pass++;
            n_checks++; if (lock_loss_count !== ((j >= 3) ? 8'd1 : 8'd0)) $display("FAIL loss_count j=%0d got %0d want %0d", j, lock_loss_count, (j >= 3) ? 1 : 0); else n_pass++;
        end
    endtask

    task automatic test_soft_rst();
        logic       exp_pll;
        logic       exp_core;
        logic [7:0] base;
        for (int j = 1; j <= 7; j++) begin
            soft_rst_req = (j == 1);
            step();
            n_checks++; if (core_reset !== (j <= 4)) $display("FAIL soft_core_reset j=%0d got %b want %b", j, core_reset, (j <= 4)); else n_pass++;
            n_checks++; if (clk_ok !== (j > 4)) $display("FAIL soft_clk_ok j=%0d got %b want %b", j, clk_ok, (j > 4)); else n_pass++;
            n_checks++; if (pll_resetb !== 1'b1) $display("FAIL soft_pll_resetb j=%0d got %b want 1", j, pll_resetb); else n_pass++;
        end
        n_checks++; if (lock_loss_count !== 8'd1) $display("FAIL soft_count got %0d want 1", lock_loss_count); else n_pass++;
        // sc 0: request coincides with lock loss in RUN; sc 1: lock lost while in SOFT_RST
        for (int sc = 0; sc < 2; sc++) begin
            base = (sc == 0) ? 8'd1 : 8'd2;
            for (int j = 1; j <= 16; j++) begin
                if (j == 1) lock_in = 1'b0;
                if (j == 4) lock_in = 1'b1;
                soft_rst_req = (sc == 0) ? (j == 3) : (j == 1);
                step();
                exp_pll  = !(j >= 3 && j <= 6);
                exp_core = (j >= ((sc == 0) ? 3 : 1)) && (j < 15);
                n_checks++; if (pll_resetb !== exp_pll) $display("FAIL softloss%0d_pll_resetb j=%0d got %b want %b", sc, j, pll_resetb, exp_pll); else n_pass++;
                n_checks++; if (core_reset !== exp_core) $display("FAIL softloss%0d_core_reset j=%0d got %b want %b", sc, j, core_reset, exp_core); else n_pass++;
                n_checks++; if (clk_ok !== !exp_core) $display("FAIL softloss%0d_clk_ok j=%0d got %b want %b", sc, j, clk_ok, !exp_core); else n_pass++;
                n_checks++; if (lock_loss_count !== ((j >= 3) ? base + 8'd1 : base)) $display("FAIL softloss%0d_count j=%0d got %0d want %0d", sc, j, lock_loss_count, (j >= 3) ? base + 8'd1 : base); else n_pass++;
            end
        end
        soft_rst_req = 1'b0;
    endtask

    task automatic test_saturation_reset();
        int exp_cnt;
        do_reset(1'b1);
        repeat (13) step();
        for (int i = 1; i <= 300; i++) begin
            lock_in = 1'b0;
            step();
            lock_in = 1'b1;
            repeat (15) step();
            exp_cnt = (i > 255) ? 255 : i;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                n_checks++; if (lock_loss_count !== 8'(exp_cnt)) $display("FAIL sat_count after %0d losses got %0d want %0d", i, lock_loss_count, exp_cnt); else n_pass++;
            end
        end
        n_checks++; if (clk_ok !== 1'b1) $display("FAIL sat_clk_ok got %b want 1", clk_ok); else n_pass++;
        // Re-sequence and stop inside STABILIZE (entered on edge 8)
        for (int j = 1; j <= 10; j++) begin
            lock_in = (j != 1);
            step();
        end
        n_checks++; if (pll_resetb !== 1'b1 || core_reset !== 1'b1) $display("FAIL stab_pre pll_resetb=%b core_reset=%b want 1 1", pll_resetb, core_reset); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (pll_resetb !== 1'b0) $display("FAIL midrst_pll_resetb got %b want 0", pll_resetb); else n_pass++;
        n_checks++; if (core_reset !== 1'b1) $display("FAIL midrst_core_reset got %b want 1", core_reset); else n_pass++;
        n_checks++; if (clk_ok !== 1'b0) $display("FAIL midrst_clk_ok got %b want 0", clk_ok); else n_pass++;
        n_checks++; if (lock_loss_count !== 8'd0) $display("FAIL midrst_count got %0d want 0", lock_loss_count); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL midrst_timeout got %b want 0", timeout); else n_pass++;
        reset = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            n_checks++; if (pll_resetb !== (n >= 4)) $display("FAIL postrst_pll_resetb edge %0d got %b want %b", n, pll_resetb, (n >= 4)); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic exp_pll;
        logic exp_to;
        do_reset(1'b0);
        for (int n = 1; n <= 80; n++) begin
            step();
`ifdef CLK_RST_TIMEOUT_EN
            exp_pll = ((n % 36) >= 4);
            exp_to  = (n >= 36);
`else
            exp_pll = (n >= 4);
            exp_to  = 1'b0;
`endif
            n_checks++; if (pll_resetb !== exp_pll) $display("FAIL tmo_pll_resetb edge %0d got %b want %b", n, pll_resetb, exp_pll); else n_pass++;
            n_checks++; if (timeout !== exp_to) $display("FAIL tmo_timeout edge %0d got %b want %b", n, timeout, exp_to); else n_pass++;
        end
        n_checks++; if (lock_loss_count !== 8'd0) $display("FAIL tmo_count got %0d want 0", lock_loss_count); else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        lock_in      = 1'b0;
        soft_rst_req = 1'b0;
        test_reset();
        test_power_up();
        test_glitch();
        test_lock_loss();
        test_soft_rst();
        test_saturation_reset();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
